// File: rtl/debounce_edge.sv
// debounce_edge: synchronises a raw asynchronous level into clk, accepts a
// new level only after it has been seen for DEBOUNCE_CYCLES consecutive
// synchronised samples, and emits one-cycle rise/fall pulses on each
// accepted change. All outputs are registered.
module debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CNT_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CNT_LO    = 2'd3
  } state_t;

  // Count value on which the last required stable sample is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single-sample qualification the counting states are skipped.
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   sync;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             q_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic             busy_reg;

  // Stage 0 is the only place d_in is sampled; each later stage takes the
  // previous one.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = d_in;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign sync = sync_reg[SYNC_STAGES-1];

  // Synchroniser chain, cleared by reset so a held input is re-qualified.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  // Qualification FSM with registered level, pulses and busy flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= STABLE_LO;
      cnt_reg   <= '0;
      q_reg     <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      case (state_reg)
        STABLE_LO: begin
          if (sync) begin
            if (SINGLE) begin
              state_reg <= STABLE_HI;
              q_reg     <= 1'b1;
              rise_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= CNT_HI;
              cnt_reg   <= CNT_ONE;
              busy_reg  <= 1'b1;
            end
          end
        end
        CNT_HI: begin
          if (sync) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg <= STABLE_HI;
              q_reg     <= 1'b1;
              rise_reg  <= 1'b1;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end else begin
            // Opposite sample: abandon the candidate, level unchanged.
            state_reg <= STABLE_LO;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        end
        STABLE_HI: begin
          if (!sync) begin
            if (SINGLE) begin
              state_reg <= STABLE_LO;
              q_reg     <= 1'b0;
              fall_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= CNT_LO;
              cnt_reg   <= CNT_ONE;
              busy_reg  <= 1'b1;
            end
          end
        end
        CNT_LO: begin
          if (!sync) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg <= STABLE_LO;
              q_reg     <= 1'b0;
              fall_reg  <= 1'b1;
              cnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end else begin
            state_reg <= STABLE_HI;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= STABLE_LO;
          cnt_reg   <= '0;
          q_reg     <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = q_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: two instances (4-cycle and 1-cycle qualification)
// share clk/n_rst/d_in. A directed vector table and hand sequences cover the
// documented timing; a random phase compares against a run-length model.
module tb_debounce_edge;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  logic d_in  = 1'b0;
  logic q_a, rise_a, fall_a, busy_a;
  logic q_b, rise_b, fall_b, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  debounce_edge #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(4)) u_dut_a (
    .clk(clk), .n_rst(n_rst), .d_in(d_in),
    .q(q_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
  );

  debounce_edge #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(1)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .d_in(d_in),
    .q(q_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
  );

  // Reference: d_in delayed by SYNC_STAGES samples, then a count of how many
  // consecutive samples have disagreed with the accepted level.
  logic [SYNC_STAGES-1:0] m_pipe;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) m_pipe <= '0;
    else        m_pipe <= {m_pipe[SYNC_STAGES-2:0], d_in};
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_model
      localparam int DEB = (gi == 0) ? 4 : 1;
      logic m_q, m_rise, m_fall;
      int   m_run;
      always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          m_q <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0; m_run <= 0;
        end else if (m_pipe[SYNC_STAGES-1] == m_q) begin
          m_run <= 0; m_rise <= 1'b0; m_fall <= 1'b0;
        end else if (m_run + 1 >= DEB) begin
          m_q <= ~m_q; m_rise <= ~m_q; m_fall <= m_q; m_run <= 0;
        end else begin
          m_run <= m_run + 1; m_rise <= 1'b0; m_fall <= 1'b0;
        end
      end
      wire [3:0] m_exp = {m_q, m_rise, m_fall, (m_run != 0)};
    end
  endgenerate

  typedef struct {
    logic       d;
    logic [3:0] exp_a;  // {q, rise, fall, busy} after the edge
    logic [3:0] exp_b;
  } vec_t;

  vec_t tbl [24];
  int   tbl_n = 0;

  task automatic add(input logic d, input logic [3:0] ea, input logic [3:0] eb);
    tbl[tbl_n] = '{d, ea, eb};
    tbl_n++;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: q/rise/fall/busy got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int hold;
    int edge_a, edge_b;
    string nm;

    // clean rise
    add(1, 4'b0000, 4'b0000); add(1, 4'b0000, 4'b0000); add(1, 4'b0001, 4'b1100);
    add(1, 4'b0001, 4'b1000); add(1, 4'b0001, 4'b1000); add(1, 4'b1100, 4'b1000);
    add(1, 4'b1000, 4'b1000); add(1, 4'b1000, 4'b1000);
    // clean fall
    add(0, 4'b1000, 4'b1000); add(0, 4'b1000, 4'b1000); add(0, 4'b1001, 4'b0010);
    add(0, 4'b1001, 4'b0000); add(0, 4'b1001, 4'b0000); add(0, 4'b0010, 4'b0000);
    add(0, 4'b0000, 4'b0000); add(0, 4'b0000, 4'b0000);
    // 3-clock glitch
    add(1, 4'b0000, 4'b0000); add(1, 4'b0000, 4'b0000); add(1, 4'b0001, 4'b1100);
    add(0, 4'b0001, 4'b1000); add(0, 4'b0001, 4'b1000); add(0, 4'b0000, 4'b0010);
    add(0, 4'b0000, 4'b0000); add(0, 4'b0000, 4'b0000);

    // Reset held with d_in high while clocking
    d_in = 1'b1;
    #2 n_rst = 1'b0;
    repeat (3) step();
    check("reset A", {q_a, rise_a, fall_a, busy_a}, 4'b0000);
    check("reset B", {q_b, rise_b, fall_b, busy_b}, 4'b0000);
    d_in = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) step();

    // Directed table
    for (int i = 0; i < tbl_n; i++) begin
      d_in = tbl[i].d;
      step();
      $display("[TB] vec %0d d=%b A=%b B=%b", i, tbl[i].d,
               {q_a, rise_a, fall_a, busy_a}, {q_b, rise_b, fall_b, busy_b});
      nm = $sformatf("vec%0d A", i);
      check(nm, {q_a, rise_a, fall_a, busy_a}, tbl[i].exp_a);
      nm = $sformatf("vec%0d B", i);
      check(nm, {q_b, rise_b, fall_b, busy_b}, tbl[i].exp_b);
    end

    // Bounce before settling low: raise q first
    d_in = 1'b1;
    repeat (8) step();
    check("pre-bounce A", {q_a, rise_a, fall_a, busy_a}, 4'b1000);
    for (int i = 0; i < 10; i++) begin
      d_in = logic'(i % 2);
      step();
      check_int("bounce hold A", int'({q_a, fall_a}), 2);
    end
    d_in = 1'b0;
    edge_a = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (fall_a) begin edge_a = n; break; end
    end
    $display("[TB] bounce settle: fall at edge %0d", edge_a);
    check_int("bounce fall edge A", edge_a, 6);
    repeat (3) step();

    // Reset mid-count, then re-qualify a held-high input
    d_in = 1'b1;
    repeat (4) step();
    check("midcount busy A", {q_a, rise_a, fall_a, busy_a}, 4'b0001);
    #2 n_rst = 1'b0;
    #1;
    check("async reset A", {q_a, rise_a, fall_a, busy_a}, 4'b0000);
    check("async reset B", {q_b, rise_b, fall_b, busy_b}, 4'b0000);
    @(negedge clk);
    n_rst = 1'b1;
    edge_a = -1;
    edge_b = -1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (rise_a && edge_a < 0) edge_a = n;
      if (rise_b && edge_b < 0) edge_b = n;
    end
    $display("[TB] post-reset rise: A edge %0d, B edge %0d", edge_a, edge_b);
    check_int("post-reset rise edge A", edge_a, 6);
    check_int("post-reset rise edge B", edge_b, 3);
    check("post-reset level A", {q_a, rise_a, fall_a, busy_a}, 4'b1000);

    // Random runs against the model, with occasional async reset
    hold = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (hold == 0) begin
        d_in = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      if (cyc % 150 == 149) begin
        n_rst = 1'b0;
        #1;
        check("rand reset A", {q_a, rise_a, fall_a, busy_a}, g_model[0].m_exp);
        check("rand reset B", {q_b, rise_b, fall_b, busy_b}, g_model[1].m_exp);
        #1 n_rst = 1'b1;
      end
      step();
      if (cyc % 50 == 0)
        $display("[TB] rand cyc %0d d=%b A=%b B=%b", cyc, d_in,
                 {q_a, rise_a, fall_a, busy_a}, {q_b, rise_b, fall_b, busy_b});
      check("rand A", {q_a, rise_a, fall_a, busy_a}, g_model[0].m_exp);
      check("rand B", {q_b, rise_b, fall_b, busy_b}, g_model[1].m_exp);
      check_int("rise&fall A", int'(rise_a & fall_a), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
